regfile_wb_sequencer: RTL and testbench
=======================================

// Module: regfile_wb_sequencer
// PURPOSE
//  Write-back sequencer that drives the register file's single write port (we/wa/wd).
//  - Accepts results from two producers: ALU results and memory loads (word or LDRB byte).
//  - Extracts and zero-extends LDRB bytes, then queues results in a DEPTH-entry FIFO.
//  - Retires one write per cycle unless the write port is stalled.
//  - Exports a per-register pending mask for hazard detection in decode.
// PARAMETERS
//  WORD        4   bytes per register
//  WIDTH       8   bits per byte
//  ADDR_WIDTH  4   regfile byte-address bits; NREG=(1<<ADDR_WIDTH)/WORD, RIDX=log2(NREG)
//  DEPTH       4   FIFO entries, power of 2, >=2
// PORTS
//  clk        in   1               rising-edge clock
//  rst        in   1               synchronous active-high reset
//  alu_valid  in   1               ALU result valid
//  alu_ready  out  1               ALU result accepted this cycle when alu_valid && alu_ready
//  alu_reg    in   RIDX            ALU destination register index
//  alu_data   in   WORD*WIDTH      ALU result
//  mem_valid  in   1               load result valid
//  mem_ready  out  1               load result accepted this cycle when mem_valid && mem_ready
//  mem_reg    in   RIDX            load destination register index
//  mem_data   in   WORD*WIDTH      raw loaded word
//  mem_byte   in   1               1=LDRB (extract one byte), 0=full word
//  mem_lane   in   log2(WORD)      byte lane for LDRB
//  stall      in   1               1 = regfile write port unavailable, no retire
//  we         out  1               regfile write enable
//  wa         out  ADDR_WIDTH*WIDTH  regfile byte address = reg*WORD, zero-extended
//  wd         out  WORD*WIDTH      regfile write data
//  pending    out  NREG            bit i=1 iff a queued (unretired) entry targets reg i
// BEHAVIOUR
//  - Reset: FIFO emptied. we=0, wa=0, wd=0, pending=0.
//    alu_ready and mem_ready follow the rules below (both 1 after reset if no mem_valid).
//    A reset mid-operation discards all queued entries; nothing is written.
//  - Accept: at most one push per cycle, with fixed priority to memory.
//    - mem_ready = !full.
//    - alu_ready = !full && !mem_valid.
//  - Full/empty are counted over occupancy after the current cycle's retire.
//    A full FIFO with a retire this cycle (!stall) still accepts a push (push+pop same edge).
//  - LDRB data = {zeros, mem_data[mem_lane*WIDTH +: WIDTH]}; word load passes mem_data unchanged.
//    Extraction happens at accept; the FIFO stores final data.
//  - Retire: we = !empty && !stall; wa/wd = head entry. Head is popped at the edge where we=1.
//    - stall=1: we=0, head held, wa/wd hold the head value.
//    - Empty: we=0, wa/wd hold the last retired value.
//  - Latency: an entry pushed at edge k into an empty FIFO appears on we/wa/wd in the cycle after edge k.
//  - Order: strictly FIFO. Two queued writes to the same reg retire oldest first, so the last accepted value wins.
//  - pending: combinational OR over valid entries; the bit clears in the cycle after its last entry retires.
//  - Pointers wrap modulo DEPTH. The count is log2(DEPTH)+1 bits and never exceeds DEPTH.
// CONFIGURATION
//  WB_BYPASS_EN defined:
//    - When the FIFO is empty and stall=0, an accepted entry is written in the same cycle (we/wa/wd are combinational from the producer) and is not queued.
//    - pending is not set for bypassed entries.
//  WB_BYPASS_EN undefined:
//    - All entries pass through the FIFO.
//    - Minimum latency is 1 cycle.
//    - we/wa/wd are driven only from FIFO state.
// TESTING
//  1. rst=1 two cycles, then idle -> we=0, wa=0, wd=0, pending=0, alu_ready=1, mem_ready=1.
//  2. ALU reg=2, data=32'hDEADBEEF, stall=0 -> next cycle we=1, wa=8, wd=DEADBEEF;
//     pending[2] high for 1 cycle (0 cycles and same-cycle write under WB_BYPASS_EN).
//  3. LDRB mem_data=32'h11223344, lane=2, reg=1 -> wd=32'h00000022, wa=4.
//     Same data with mem_byte=0 -> wd=11223344.
//  4. stall=1, push 4 ALU writes -> 5th push: alu_ready=0, mem_ready=0, pending shows all targets.
//     Drop stall -> four writes on consecutive cycles in push order.
//  5. mem_valid and alu_valid in the same cycle -> mem accepted, alu_ready=0.
//     ALU accepted the next cycle; writes retire in order mem, alu.
//  6. Full FIFO, stall=0, push + retire in the same cycle -> accepted, count stays 4.
//     Later rst mid-drain -> we=0 next cycle, pending=0, no further writes.

Source files
------------

// File: rtl/regfile_wb_sequencer.sv
// Write-back sequencer: queues ALU and load results in a small FIFO and drains them into the
// register file's single write port. Optional macro WB_BYPASS_EN: write-through when idle.
module regfile_wb_sequencer #(
  parameter int WORD       = 4,
  parameter int WIDTH      = 8,
  parameter int ADDR_WIDTH = 4,
  parameter int DEPTH      = 4,
  localparam int NREG = (1 << ADDR_WIDTH) / WORD,
  localparam int RIDX = (NREG > 1) ? $clog2(NREG) : 1,
  localparam int LW   = (WORD > 1) ? $clog2(WORD) : 1,
  localparam int DW   = WORD * WIDTH,
  localparam int AW   = ADDR_WIDTH * WIDTH
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            alu_valid,
  output logic            alu_ready,
  input  logic [RIDX-1:0] alu_reg,
  input  logic [DW-1:0]   alu_data,
  input  logic            mem_valid,
  output logic            mem_ready,
  input  logic [RIDX-1:0] mem_reg,
  input  logic [DW-1:0]   mem_data,
  input  logic            mem_byte,
  input  logic [LW-1:0]   mem_lane,
  input  logic            stall,
  output logic            we,
  output logic [AW-1:0]   wa,
  output logic [DW-1:0]   wd,
  output logic [NREG-1:0] pending
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [RIDX-1:0]  fifo_reg  [DEPTH];
  logic [DW-1:0]    fifo_data [DEPTH];
  logic [PW-1:0]    wr_ptr, rd_ptr;
  logic [CW-1:0]    count;
  logic [CW-1:0]    occ_after;
  logic [RIDX-1:0]  last_reg;
  logic [DW-1:0]    last_data;
  logic [WIDTH-1:0] lane_byte;
  logic [RIDX-1:0]  in_reg;
  logic [DW-1:0]    in_data;
  logic             pop, full, push_mem, push_alu, push, bypass, q_push;

  function automatic logic [AW-1:0] byte_addr(input logic [RIDX-1:0] r);
    return AW'(r) * AW'(WORD);
  endfunction

  // Readiness looks at occupancy after this cycle's retire, so a full FIFO that drains still accepts.
  assign pop       = (count != '0) && !stall;
  assign occ_after = count - CW'(pop);
  assign full      = (occ_after == CW'(DEPTH));
  assign mem_ready = !full;
  assign alu_ready = !full && !mem_valid;
  assign push_mem  = mem_valid && mem_ready;
  assign push_alu  = alu_valid && alu_ready;
  assign push      = push_mem || push_alu;

  assign lane_byte = mem_data[mem_lane*WIDTH +: WIDTH];
  assign in_reg    = push_mem ? mem_reg : alu_reg;
  assign in_data   = !push_mem ? alu_data : (mem_byte ? DW'(lane_byte) : mem_data);

`ifdef WB_BYPASS_EN
  assign bypass = (count == '0) && !stall && push;
`else
  assign bypass = 1'b0;
`endif
  assign q_push = push && !bypass;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      last_reg  <= '0;
      last_data <= '0;
    end else begin
      if (q_push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) begin
        rd_ptr    <= rd_ptr + 1'b1;
        last_reg  <= fifo_reg[rd_ptr];
        last_data <= fifo_data[rd_ptr];
      end else if (bypass) begin
        last_reg  <= in_reg;
        last_data <= in_data;
      end
      count <= count + CW'(q_push) - CW'(pop);
    end
  end

  // NOTE: storage has no reset; entries are only read while count marks them valid.
  always_ff @(posedge clk) begin
    if (q_push) begin
      fifo_reg[wr_ptr]  <= in_reg;
      fifo_data[wr_ptr] <= in_data;
    end
  end

  // NOTE: every output gets a default first so no latch is inferred.
  always_comb begin
    we = pop;
    wa = byte_addr(last_reg);
    wd = last_data;
    if (bypass) begin
      we = 1'b1;
      wa = byte_addr(in_reg);
      wd = in_data;
    end else if (count != '0) begin
      wa = byte_addr(fifo_reg[rd_ptr]);
      wd = fifo_data[rd_ptr];
    end
  end

  always_comb begin
    pending = '0;
    for (int k = 0; k < DEPTH; k++) begin
      if (CW'(k) < count) pending[fifo_reg[rd_ptr + PW'(k)]] = 1'b1;
    end
  end

endmodule

// File: tb/tb_regfile_wb_sequencer.sv
// Self-checking bench for regfile_wb_sequencer: directed scenarios plus random traffic
// checked against a queue-based model of the write-back rules.
module tb_regfile_wb_sequencer;

`ifdef WB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif
  localparam int DEPTH = 4;

  typedef struct packed {
    logic        we;
    logic [31:0] wa;
    logic [31:0] wd;
    logic [3:0]  pending;
    logic        alu_ready;
    logic        mem_ready;
  } obs_t;

  typedef struct packed {
    logic [1:0]  r;
    logic [31:0] d;
  } ent_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        alu_valid = 1'b0, mem_valid = 1'b0, mem_byte = 1'b0, stall = 1'b0;
  logic [1:0]  alu_reg = '0, mem_reg = '0, mem_lane = '0;
  logic [31:0] alu_data = '0, mem_data = '0;
  logic        alu_ready, mem_ready, we;
  logic [31:0] wa, wd;
  logic [3:0]  pending;

  int checks = 0;
  int failures = 0;

  ent_t        m_q[$];
  logic [1:0]  last_r = '0;
  logic [31:0] last_d = '0;

  regfile_wb_sequencer dut (
    .clk(clk), .rst(rst),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_reg(alu_reg), .alu_data(alu_data),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_reg(mem_reg), .mem_data(mem_data),
    .mem_byte(mem_byte), .mem_lane(mem_lane), .stall(stall),
    .we(we), .wa(wa), .wd(wd), .pending(pending)
  );

  always #5 clk = ~clk;

  // Samples DUT and model at the falling edge, then advances the model across the rising edge.
  task automatic step(output obs_t o, output obs_t e);
    int   n;
    logic pop, full, acc_mem, acc_alu, byp;
    ent_t ent;
    @(negedge clk);
    n    = m_q.size();
    pop  = (n > 0) && !stall;
    full = (n - (pop ? 1 : 0)) == DEPTH;
    e = '0;
    e.mem_ready = !full;
    e.alu_ready = !full && !mem_valid;
    acc_mem = mem_valid && e.mem_ready;
    acc_alu = alu_valid && e.alu_ready;
    ent.r = acc_mem ? mem_reg : alu_reg;
    ent.d = acc_mem ? (mem_byte ? ((mem_data >> (8 * mem_lane)) & 32'hFF) : mem_data) : alu_data;
    byp = BYP && (n == 0) && !stall && (acc_mem || acc_alu);
    if (byp) begin
      e.we = 1'b1;
      e.wa = 32'(ent.r) * 4;
      e.wd = ent.d;
    end else begin
      e.we = pop;
      e.wa = (n > 0) ? 32'(m_q[0].r) * 4 : 32'(last_r) * 4;
      e.wd = (n > 0) ? m_q[0].d : last_d;
    end
    foreach (m_q[i]) e.pending[m_q[i].r] = 1'b1;
    o.we = we; o.wa = wa; o.wd = wd; o.pending = pending;
    o.alu_ready = alu_ready; o.mem_ready = mem_ready;
    @(posedge clk);
    if (rst) begin
      m_q.delete();
      last_r = '0;
      last_d = '0;
    end else begin
      if (pop) begin
        last_r = m_q[0].r;
        last_d = m_q[0].d;
        void'(m_q.pop_front());
      end
      if (byp) begin
        last_r = ent.r;
        last_d = ent.d;
      end else if (acc_mem || acc_alu) begin
        m_q.push_back(ent);
      end
    end
    #1;
  endtask

  task automatic idle(input logic st);
    alu_valid = 1'b0;
    mem_valid = 1'b0;
    mem_byte  = 1'b0;
    stall     = st;
  endtask

  task automatic drain();
    obs_t o, e;
    idle(1'b0);
    for (int i = 0; i < DEPTH + 1; i++) begin
      step(o, e);
      checks++;
      if (o !== e) begin failures++; $display("FAIL drain: got %h expected %h", o, e); end
    end
  endtask

  task automatic test_reset();
    obs_t o, e;
    rst = 1'b1;
    idle(1'b0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    m_q.delete();
    last_r = '0;
    last_d = '0;
    step(o, e);
    checks++;
    if (o !== e) begin failures++; $display("FAIL reset_model: got %h expected %h", o, e); end
    checks++;
    if (o.we !== 1'b0 || o.wa !== 32'h0 || o.wd !== 32'h0 || o.pending !== 4'h0 ||
        o.alu_ready !== 1'b1 || o.mem_ready !== 1'b1)
      begin failures++; $display("FAIL reset_state: got %h expected we=0 wa=0 wd=0 pending=0 ready=1,1", o); end
  endtask

  task automatic test_alu_write();
    obs_t o, e, w;
    alu_valid = 1'b1; alu_reg = 2'd2; alu_data = 32'hDEADBEEF; stall = 1'b0;
    step(o, e);
    checks++;
    if (o !== e) begin failures++; $display("FAIL alu_push: got %h expected %h", o, e); end
    w = o;
    idle(1'b0);
    if (!BYP) begin
      step(o, e);
      checks++;
      if (o !== e) begin failures++; $display("FAIL alu_retire: got %h expected %h", o, e); end
      w = o;
    end
    checks++;
    if (w.we !== 1'b1 || w.wa !== 32'd8 || w.wd !== 32'hDEADBEEF || w.pending !== (BYP ? 4'b0000 : 4'b0100))
      begin failures++; $display("FAIL alu_write: got %h expected we=1 wa=8 wd=deadbeef", w); end
    step(o, e);
    checks++;
    if (o.we !== 1'b0 || o.pending !== 4'h0 || o.wa !== 32'd8 || o.wd !== 32'hDEADBEEF)
      begin failures++; $display("FAIL alu_after: got %h expected we=0 pending=0 wa/wd held", o); end
  endtask

  task automatic test_ldrb();
    obs_t o, e;
    logic [63:0] wr[4];
    int nw = 0;
    mem_valid = 1'b1; mem_reg = 2'd1; mem_data = 32'h11223344; mem_byte = 1'b1; mem_lane = 2'd2;
    for (int i = 0; i < 4; i++) begin
      if (i == 1) mem_byte = 1'b0;
      if (i == 2) idle(1'b0);
      step(o, e);
      checks++;
      if (o !== e) begin failures++; $display("FAIL ldrb_cycle%0d: got %h expected %h", i, o, e); end
      if (o.we === 1'b1 && nw < 4) begin wr[nw] = {o.wa, o.wd}; nw++; end
    end
    checks++;
    if (nw !== 2 || wr[0] !== {32'd4, 32'h00000022} || wr[1] !== {32'd4, 32'h11223344})
      begin failures++; $display("FAIL ldrb_writes: got n=%0d %h %h expected 2 writes 4/22 then 4/11223344", nw, wr[0], wr[1]); end
  endtask

  task automatic test_full_stall();
    obs_t o, e;
    logic [31:0] d[4];
    stall = 1'b1;
    for (int i = 0; i < 4; i++) begin
      alu_valid = 1'b1; alu_reg = 2'(i); d[i] = $urandom; alu_data = d[i];
      step(o, e);
      checks++;
      if (o !== e) begin failures++; $display("FAIL fill%0d: got %h expected %h", i, o, e); end
    end
    mem_valid = 1'b1; mem_reg = 2'd0; mem_data = $urandom;
    alu_data = $urandom;
    step(o, e);
    checks++;
    if (o !== e) begin failures++; $display("FAIL fifth_push: got %h expected %h", o, e); end
    checks++;
    if (o.alu_ready !== 1'b0 || o.mem_ready !== 1'b0 || o.pending !== 4'hF || o.we !== 1'b0)
      begin failures++; $display("FAIL full_state: got %h expected ready=0,0 pending=f we=0", o); end
    idle(1'b0);
    for (int i = 0; i < 4; i++) begin
      step(o, e);
      checks++;
      if (o.we !== 1'b1 || o.wa !== 32'(i * 4) || o.wd !== d[i])
        begin failures++; $display("FAIL drain_order%0d: got we=%b wa=%h wd=%h expected 1 %h %h", i, o.we, o.wa, o.wd, i * 4, d[i]); end
    end
    step(o, e);
    checks++;
    if (o !== e || o.we !== 1'b0) begin failures++; $display("FAIL drained: got %h expected %h", o, e); end
  endtask

  task automatic test_priority();
    obs_t o, e;
    logic [31:0] wr[4];
    int nw = 0;
    logic [31:0] da, db;
    da = $urandom; db = $urandom;
    stall = 1'b0;
    mem_valid = 1'b1; mem_reg = 2'd3; mem_data = da; mem_byte = 1'b0;
    alu_valid = 1'b1; alu_reg = 2'd0; alu_data = db;
    for (int i = 0; i < 4; i++) begin
      if (i == 1) mem_valid = 1'b0;
      if (i == 2) idle(1'b0);
      step(o, e);
      checks++;
      if (o !== e) begin failures++; $display("FAIL prio_cycle%0d: got %h expected %h", i, o, e); end
      if (i == 0) begin
        checks++;
        if (o.alu_ready !== 1'b0 || o.mem_ready !== 1'b1)
          begin failures++; $display("FAIL prio_ready: got alu=%b mem=%b expected 0 1", o.alu_ready, o.mem_ready); end
      end
      if (o.we === 1'b1 && nw < 4) begin wr[nw] = o.wd; nw++; end
    end
    checks++;
    if (nw !== 2 || wr[0] !== da || wr[1] !== db)
      begin failures++; $display("FAIL prio_order: got n=%0d %h %h expected %h %h", nw, wr[0], wr[1], da, db); end
  endtask

  task automatic test_push_pop_full();
    obs_t o, e;
    stall = 1'b1;
    for (int i = 0; i < 4; i++) begin
      alu_valid = 1'b1; alu_reg = 2'(3 - i); alu_data = $urandom;
      step(o, e);
      checks++;
      if (o !== e) begin failures++; $display("FAIL ppf_fill%0d: got %h expected %h", i, o, e); end
    end
    stall = 1'b0; alu_reg = 2'd1; alu_data = $urandom;
    step(o, e);
    checks++;
    if (o !== e || o.alu_ready !== 1'b1 || o.we !== 1'b1)
      begin failures++; $display("FAIL ppf_accept: got %h expected %h", o, e); end
    stall = 1'b1; alu_data = $urandom;
    step(o, e);
    checks++;
    if (o !== e || o.alu_ready !== 1'b0)
      begin failures++; $display("FAIL ppf_still_full: got %h expected %h", o, e); end
  endtask

  task automatic test_reset_mid_drain();
    obs_t o, e;
    idle(1'b0);
    step(o, e);
    checks++;
    if (o !== e || o.we !== 1'b1) begin failures++; $display("FAIL rmd_drain: got %h expected %h", o, e); end
    rst = 1'b1;
    step(o, e);
    checks++;
    if (o !== e) begin failures++; $display("FAIL rmd_reset_cycle: got %h expected %h", o, e); end
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step(o, e);
      checks++;
      if (o.we !== 1'b0 || o.pending !== 4'h0 || o.wa !== 32'h0 || o.wd !== 32'h0 || o.mem_ready !== 1'b1)
        begin failures++; $display("FAIL rmd_after%0d: got %h expected we=0 pending=0 wa=0 wd=0", i, o); end
    end
  endtask

  task automatic test_random();
    obs_t o, e;
    for (int c = 0; c < 600; c++) begin
      rst       = ($urandom_range(0, 79) == 0);
      stall     = ($urandom_range(0, 3) == 0);
      alu_valid = $urandom_range(0, 1);
      mem_valid = ($urandom_range(0, 2) == 0);
      alu_reg   = 2'($urandom);
      mem_reg   = 2'($urandom);
      mem_lane  = 2'($urandom);
      mem_byte  = $urandom_range(0, 1);
      alu_data  = $urandom;
      mem_data  = $urandom;
      step(o, e);
      checks++;
      if (o !== e) begin failures++; $display("FAIL random_c%0d: got %h expected %h", c, o, e); end
    end
    rst = 1'b0;
  endtask

  initial begin
    test_reset();
    test_alu_write();
    test_ldrb();
    drain();
    test_full_stall();
    test_priority();
    drain();
    test_push_pop_full();
    test_reset_mid_drain();
    test_random();
    drain();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
